// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM state encoding,
// ALU opcode values and default cycle counts.
package alu_seq_pkg;

    localparam int DW_DEF         = 32;
    localparam int OPW_DEF        = 4;
    localparam int SETUP_CYC_DEF  = 2;
    localparam int STROBE_CYC_DEF = 4;
    localparam int SETTLE_CYC_DEF = 8;

    // Opcode values as decoded by the ALU
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_XOR = 4'd4;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_A_SET  = 4'd1,
        S_A_STB  = 4'd2,
        S_B_SET  = 4'd3,
        S_B_STB  = 4'd4,
        S_F_SET  = 4'd5,
        S_F_STB  = 4'd6,
        S_SETTLE = 4'd7,
        S_DONE   = 4'd8
    } seq_state_e;

    // Largest of three cycle counts
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width able to hold max_cnt-1; never narrower than one bit
    function automatic int cnt_width(input int max_cnt);
        return (max_cnt > 1) ? $clog2(max_cnt) : 1;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_chk.sv
// Protocol checker for the sequencer's ALU-side and result-side outputs.
module alu_op_sequencer_chk (
    input logic clk,
    input logic rst,
    input logic alu_ld_a,
    input logic alu_ld_b,
    input logic alu_ld_f,
    input logic res_valid,
    input logic res_ready
);

    // The ALU load strobes must never be high together
    a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0({alu_ld_a, alu_ld_b, alu_ld_f}));

    // An offered result stays offered until it is taken
    a_res_hold: assert property (@(posedge clk) disable iff (rst)
        (res_valid && !res_ready) |=> res_valid);

endmodule

// File: rtl/alu_op_sequencer_timer.sv
// Loadable down-counter used to time every sequencer state. It stops at
// zero and reports zero combinationally from the count register.
module seq_timer #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] cnt_r;

    // Count down toward zero; a load takes priority over counting
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {TW{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {TW{1'b0}}) begin
            cnt_r <= cnt_r - TW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {TW{1'b0}});

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the multi-function ALU. Accepts one (A, B, opcode)
// command, plays it onto the shared switch bus with A/B/F load strobes in that
// order with setup and hold margins, waits for the ALU to settle, then returns
// the captured result and flags on a valid/ready handshake.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int OPW        = OPW_DEF,
    parameter int SETUP_CYC  = SETUP_CYC_DEF,
    parameter int STROBE_CYC = STROBE_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [DW-1:0]  cmd_a,
    input  logic [DW-1:0]  cmd_b,
    input  logic [OPW-1:0] cmd_op,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [DW-1:0]  res_f,
    output logic [3:0]     res_fr,
    output logic [DW-1:0]  alu_sw,
    output logic           alu_ld_a,
    output logic           alu_ld_b,
    output logic           alu_ld_f,
    input  logic [DW-1:0]  alu_f,
    input  logic [3:0]     alu_fr
);

    localparam int TW = cnt_width(max3(SETUP_CYC, STROBE_CYC, SETTLE_CYC));

    // Timer reload values: each state lasts (load value + 1) cycles
    localparam logic [TW-1:0] SETUP_LD  = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] STROBE_LD = TW'(STROBE_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);

    seq_state_e     state_r;
    logic [DW-1:0]  a_r;
    logic [DW-1:0]  b_r;
    logic [OPW-1:0] op_r;

    logic           tmr_load_s;
    logic [TW-1:0]  tmr_val_s;
    logic           tmr_zero_s;
    logic           cmd_accept_s;
    logic [DW-1:0]  op_ext_s;

    assign cmd_ready    = (state_r == S_IDLE) && !rst;
    assign cmd_accept_s = cmd_valid && cmd_ready;
    assign op_ext_s     = {{(DW-OPW){1'b0}}, op_r};

    seq_timer #(
        .TW (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Timer reload on every state entry, mirroring the FSM transitions below
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = {TW{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (cmd_accept_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETUP_LD;
                end else begin
                    tmr_load_s = 1'b0;
                    tmr_val_s  = {TW{1'b0}};
                end
            end
            S_A_SET, S_B_SET, S_F_SET: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = STROBE_LD;
                end else begin
                    tmr_load_s = 1'b0;
                    tmr_val_s  = {TW{1'b0}};
                end
            end
            S_A_STB, S_B_STB: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETUP_LD;
                end else begin
                    tmr_load_s = 1'b0;
                    tmr_val_s  = {TW{1'b0}};
                end
            end
            S_F_STB: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETTLE_LD;
                end else begin
                    tmr_load_s = 1'b0;
                    tmr_val_s  = {TW{1'b0}};
                end
            end
            S_SETTLE: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = {TW{1'b0}};
                end else begin
                    tmr_load_s = 1'b0;
                    tmr_val_s  = {TW{1'b0}};
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = {TW{1'b0}};
                end else begin
                    tmr_load_s = 1'b0;
                    tmr_val_s  = {TW{1'b0}};
                end
            end
            default: begin
                tmr_load_s = 1'b0;
                tmr_val_s  = {TW{1'b0}};
            end
        endcase
    end

    // Sequencer FSM: sequences bus and strobes, then captures and offers the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            alu_sw    <= {DW{1'b0}};
            alu_ld_a  <= 1'b0;
            alu_ld_b  <= 1'b0;
            alu_ld_f  <= 1'b0;
            res_valid <= 1'b0;
            res_f     <= {DW{1'b0}};
            res_fr    <= 4'd0;
            a_r       <= {DW{1'b0}};
            b_r       <= {DW{1'b0}};
            op_r      <= {OPW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cmd_accept_s) begin
                        a_r     <= cmd_a;
                        b_r     <= cmd_b;
                        op_r    <= cmd_op;
                        alu_sw  <= cmd_a;
                        state_r <= S_A_SET;
                    end
                end
                S_A_SET: begin
                    alu_sw <= a_r;
                    if (tmr_zero_s) begin
                        alu_ld_a <= 1'b1;
                        state_r  <= S_A_STB;
                    end
                end
                S_A_STB: begin
                    if (tmr_zero_s) begin
                        // Strobe falls and the bus moves to B on the same edge
                        alu_ld_a <= 1'b0;
                        alu_sw   <= b_r;
                        state_r  <= S_B_SET;
                    end
                end
                S_B_SET: begin
                    alu_sw <= b_r;
                    if (tmr_zero_s) begin
                        alu_ld_b <= 1'b1;
                        state_r  <= S_B_STB;
                    end
                end
                S_B_STB: begin
                    if (tmr_zero_s) begin
                        alu_ld_b <= 1'b0;
                        alu_sw   <= op_ext_s;
                        state_r  <= S_F_SET;
                    end
                end
                S_F_SET: begin
                    alu_sw <= op_ext_s;
                    if (tmr_zero_s) begin
                        alu_ld_f <= 1'b1;
                        state_r  <= S_F_STB;
                    end
                end
                S_F_STB: begin
                    if (tmr_zero_s) begin
                        // Opcode stays on the bus until the next command
                        alu_ld_f <= 1'b0;
                        state_r  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (tmr_zero_s) begin
                        res_f     <= alu_f;
                        res_fr    <= alu_fr;
                        res_valid <= 1'b1;
                        state_r   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    alu_ld_a  <= 1'b0;
                    alu_ld_b  <= 1'b0;
                    alu_ld_f  <= 1'b0;
                    res_valid <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
